// File: rtl/rs232_pkg.sv
// -----------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the RS-232 port: register offsets inside the
// 4-address window, status bit positions, receiver tick counts and the
// TX/RX state encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package rs232_pkg;

    // Register offsets within the 4-address window
    localparam logic [1:0] OFS_TX_DATA   = 2'd0;
    localparam logic [1:0] OFS_TX_STATUS = 2'd1;
    localparam logic [1:0] OFS_RX_DATA   = 2'd2;
    localparam logic [1:0] OFS_RX_STATUS = 2'd3;

    // TX status register bit positions
    localparam int TX_FULL_BIT  = 0;
    localparam int TX_EMPTY_BIT = 1;
    localparam int TX_BUSY_BIT  = 2;

    // RX status register bit positions
    localparam int RX_AVAIL_BIT   = 0;
    localparam int RX_OVERRUN_BIT = 1;
    localparam int RX_FRAMING_BIT = 2;

    // Receiver runs at 8 ticks per bit: the start bit is re-checked at its
    // middle (4 ticks after the falling edge), then every bit 8 ticks apart.
    localparam logic [2:0] RX_CONFIRM_CNT = 3'd3;
    localparam logic [2:0] RX_BIT_CNT     = 3'd7;
    localparam logic [2:0] LAST_DATA_BIT  = 3'd7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through head output.
// Ports:
//   clk, reset        clock and synchronous active-high reset (empties FIFO)
//   push, push_data   write request and data; dropped when full unless a pop
//                     happens in the same cycle
//   pop               remove head entry; ignored when empty
//   head              current head entry (undefined content when empty)
//   empty, full       occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO that is popped this cycle frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rs232_port.sv
// -----------------------------------------------------------------------------
// rs232_port
// Memory-mapped 8N1 UART with TX and RX FIFOs in a 4-address window.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   reset_complete        high from the first clock after reset releases
//   rs232_tx_clk_en       one-clock pulse per serial bit period
//   rs232_rx_clk_en       one-clock pulse at 8x the bit rate
//   rx_pin, tx_pin        serial input/output, idle high
//   outbus_addr/data/we   write bus (offset 0 queues a TX byte)
//   inbus_addr/data/re    combinational read bus (offset 2/3 reads have
//                         side effects when inbus_re is high)
// -----------------------------------------------------------------------------
module rs232_port #(
    parameter int DEVADDR    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       reset_complete,
    input  logic       rs232_tx_clk_en,
    input  logic       rs232_rx_clk_en,
    input  logic       rx_pin,
    output logic       tx_pin,
    input  logic [7:0] outbus_addr,
    input  logic [7:0] outbus_data,
    input  logic       outbus_we,
    input  logic [7:0] inbus_addr,
    output logic [7:0] inbus_data,
    input  logic       inbus_re
);
    import rs232_pkg::*;

    localparam logic [7:0] BASE = 8'(DEVADDR);

    logic       out_hit, in_hit;
    logic       tx_push, tx_pop, tx_empty, tx_full, tx_busy;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_empty, rx_full, rx_status_read;
    logic [7:0] rx_head;

    tx_state_t  tx_state, tx_state_next;
    logic [7:0] tx_shift, tx_shift_next;
    logic [2:0] tx_cnt, tx_cnt_next;
    logic       tx_pin_next;

    logic [1:0] rx_sync;
    logic       rx_bit;
    rx_state_t  rx_state, rx_state_next;
    logic [2:0] rx_tick_cnt, rx_tick_cnt_next;
    logic [2:0] rx_bit_cnt, rx_bit_cnt_next;
    logic [7:0] rx_shift, rx_shift_next;
    logic       rx_overflow, rx_frame_bad;
    logic       overrun, framing_err;

    assign out_hit        = (outbus_addr[7:2] == BASE[7:2]);
    assign in_hit         = (inbus_addr[7:2] == BASE[7:2]);
    assign tx_push        = outbus_we && out_hit && (outbus_addr[1:0] == OFS_TX_DATA);
    assign rx_pop         = inbus_re && in_hit && (inbus_addr[1:0] == OFS_RX_DATA);
    assign rx_status_read = inbus_re && in_hit && (inbus_addr[1:0] == OFS_RX_STATUS);
    assign tx_busy        = (tx_state != TX_IDLE);
    assign rx_bit         = rx_sync[1];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .push_data(outbus_data),
        .pop(tx_pop), .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift_next),
        .pop(rx_pop), .head(rx_head), .empty(rx_empty), .full(rx_full)
    );

    // Transmitter: STOP behaves like IDLE when deciding whether to chain the
    // next queued byte straight into a new start bit.
    always_comb begin
        tx_state_next = tx_state;
        tx_shift_next = tx_shift;
        tx_cnt_next   = tx_cnt;
        tx_pin_next   = tx_pin;
        tx_pop        = 1'b0;
        if (rs232_tx_clk_en) begin
            case (tx_state)
                TX_IDLE, TX_STOP: begin
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = tx_head;
                        tx_pin_next   = 1'b0;
                        tx_state_next = TX_START;
                    end else begin
                        tx_pin_next   = 1'b1;
                        tx_state_next = TX_IDLE;
                    end
                end
                TX_START: begin
                    tx_pin_next   = tx_shift[0];
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                    tx_cnt_next   = '0;
                    tx_state_next = TX_DATA;
                end
                TX_DATA: begin
                    if (tx_cnt == LAST_DATA_BIT) begin
                        tx_pin_next   = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_pin_next   = tx_shift[0];
                        tx_shift_next = {1'b0, tx_shift[7:1]};
                        tx_cnt_next   = tx_cnt + 3'd1;
                    end
                end
                default: tx_state_next = TX_IDLE;
            endcase
        end
    end

    // Receiver: tick counter paces the mid-bit sampling points; the byte is
    // only handed to the FIFO once a valid stop bit has been seen.
    always_comb begin
        rx_state_next    = rx_state;
        rx_tick_cnt_next = rx_tick_cnt;
        rx_bit_cnt_next  = rx_bit_cnt;
        rx_shift_next    = rx_shift;
        rx_push          = 1'b0;
        rx_overflow      = 1'b0;
        rx_frame_bad     = 1'b0;
        if (rs232_rx_clk_en) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_bit) begin
                        rx_tick_cnt_next = '0;
                        rx_state_next    = RX_START;
                    end
                end
                RX_START: begin
                    if (rx_tick_cnt == RX_CONFIRM_CNT) begin
                        rx_tick_cnt_next = '0;
                        rx_bit_cnt_next  = '0;
                        rx_state_next    = rx_bit ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_cnt_next = rx_tick_cnt + 3'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick_cnt == RX_BIT_CNT) begin
                        rx_shift_next    = {rx_bit, rx_shift[7:1]};
                        rx_tick_cnt_next = '0;
                        rx_bit_cnt_next  = rx_bit_cnt + 3'd1;
                        if (rx_bit_cnt == LAST_DATA_BIT) rx_state_next = RX_STOP;
                    end else begin
                        rx_tick_cnt_next = rx_tick_cnt + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick_cnt == RX_BIT_CNT) begin
                        if (!rx_bit)                rx_frame_bad = 1'b1;
                        else if (rx_full && !rx_pop) rx_overflow  = 1'b1;
                        else                         rx_push      = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_tick_cnt_next = rx_tick_cnt + 3'd1;
                    end
                end
                default: rx_state_next = RX_IDLE;
            endcase
        end
    end

    // State registers, synchroniser and sticky error flags. A new error in
    // the same cycle as a status read wins so the event is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            reset_complete <= 1'b0;
            tx_state       <= TX_IDLE;
            tx_shift       <= '0;
            tx_cnt         <= '0;
            tx_pin         <= 1'b1;
            rx_sync        <= 2'b11;
            rx_state       <= RX_IDLE;
            rx_tick_cnt    <= '0;
            rx_bit_cnt     <= '0;
            rx_shift       <= '0;
            overrun        <= 1'b0;
            framing_err    <= 1'b0;
        end else begin
            reset_complete <= 1'b1;
            tx_state       <= tx_state_next;
            tx_shift       <= tx_shift_next;
            tx_cnt         <= tx_cnt_next;
            tx_pin         <= tx_pin_next;
            rx_sync        <= {rx_sync[0], rx_pin};
            rx_state       <= rx_state_next;
            rx_tick_cnt    <= rx_tick_cnt_next;
            rx_bit_cnt     <= rx_bit_cnt_next;
            rx_shift       <= rx_shift_next;
            if (rx_overflow)         overrun <= 1'b1;
            else if (rx_status_read) overrun <= 1'b0;
            if (rx_frame_bad)        framing_err <= 1'b1;
            else if (rx_status_read) framing_err <= 1'b0;
        end
    end

    // Combinational read mux; anything outside the window reads as zero.
    always_comb begin
        inbus_data = 8'h00;
        if (in_hit) begin
            case (inbus_addr[1:0])
                OFS_TX_STATUS: begin
                    inbus_data[TX_FULL_BIT]  = tx_full;
                    inbus_data[TX_EMPTY_BIT] = tx_empty;
                    inbus_data[TX_BUSY_BIT]  = tx_busy;
                end
                OFS_RX_DATA: inbus_data = rx_empty ? 8'h00 : rx_head;
                OFS_RX_STATUS: begin
                    inbus_data[RX_AVAIL_BIT]   = !rx_empty;
                    inbus_data[RX_OVERRUN_BIT] = overrun;
                    inbus_data[RX_FRAMING_BIT] = framing_err;
                end
                default: inbus_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_port.sv
// -----------------------------------------------------------------------------
// tb_rs232_port
// Self-checking bench for rs232_port. Read checks go through a scoreboard
// queue drained by a monitor; transmitted frames are decoded by a line
// monitor and matched against a queue of expected bytes. The reference model
// keeps the RX FIFO as a plain queue plus two sticky flags.
// -----------------------------------------------------------------------------
module tb_rs232_port;

    localparam int         DEPTH = 4;
    localparam logic [7:0] BASE  = 8'h40;
    localparam logic [7:0] A_TXD = BASE;
    localparam logic [7:0] A_TXS = BASE + 8'd1;
    localparam logic [7:0] A_RXD = BASE + 8'd2;
    localparam logic [7:0] A_RXS = BASE + 8'd3;

    logic       clk;
    logic       reset;
    logic       reset_complete;
    logic       rs232_tx_clk_en;
    logic       rs232_rx_clk_en;
    logic       rx_pin;
    logic       tx_pin;
    logic [7:0] outbus_addr;
    logic [7:0] outbus_data;
    logic       outbus_we;
    logic [7:0] inbus_addr;
    logic [7:0] inbus_data;
    logic       inbus_re;

    logic       loopback;
    logic       rx_drive;
    logic       tx_run;
    logic       chk_req;

    int total;
    int bad;

    logic [7:0] rd_exp_q[$];
    string      rd_name_q[$];
    logic [7:0] tx_exp_q[$];

    logic [7:0] model_rx_q[$];
    logic       model_overrun;
    logic       model_framing;

    assign rx_pin = loopback ? tx_pin : rx_drive;

    rs232_port #(.DEVADDR(64), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .reset_complete(reset_complete),
        .rs232_tx_clk_en(rs232_tx_clk_en),
        .rs232_rx_clk_en(rs232_rx_clk_en),
        .rx_pin(rx_pin),
        .tx_pin(tx_pin),
        .outbus_addr(outbus_addr),
        .outbus_data(outbus_data),
        .outbus_we(outbus_we),
        .inbus_addr(inbus_addr),
        .inbus_data(inbus_data),
        .inbus_re(inbus_re)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bit-rate ticks: TX every 16 clocks (stallable), RX every 2 clocks.
    initial begin
        int tc;
        int rc;
        tc = 0;
        rc = 0;
        rs232_tx_clk_en = 1'b0;
        rs232_rx_clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tc = (tc == 15) ? 0 : tc + 1;
            rc = 1 - rc;
            rs232_tx_clk_en = tx_run && (tc == 15);
            rs232_rx_clk_en = (rc == 1);
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Read monitor: compares the combinational read data mid-cycle.
    initial begin
        logic [7:0] e;
        string      n;
        forever begin
            @(negedge clk);
            if (chk_req) begin
                total++;
                if (rd_exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL read_without_expectation: got=%02h expected=none", inbus_data);
                end else begin
                    e = rd_exp_q.pop_front();
                    n = rd_name_q.pop_front();
                    if (inbus_data !== e) begin
                        bad++;
                        $display("[TB] FAIL %s: got=%02h expected=%02h", n, inbus_data, e);
                    end
                end
            end
        end
    end

    // Line monitor: decodes 8N1 frames on tx_pin at each TX tick.
    initial begin
        logic [8:0] fr;
        int         nb;
        bit         in_frame;
        logic       t;
        logic       r;
        logic [7:0] e;
        in_frame = 0;
        nb = 0;
        fr = '0;
        forever begin
            @(posedge clk);
            t = rs232_tx_clk_en;
            r = reset;
            #2;
            if (r) begin
                in_frame = 0;
                nb = 0;
            end else if (t) begin
                if (!in_frame) begin
                    if (tx_pin === 1'b0) begin
                        in_frame = 1;
                        nb = 0;
                    end
                end else begin
                    fr = {tx_pin, fr[8:1]};
                    nb++;
                    if (nb == 9) begin
                        in_frame = 0;
                        total++;
                        if (tx_exp_q.size() == 0) begin
                            bad++;
                            $display("[TB] FAIL tx_unexpected_frame: got=%02h expected=none", fr[7:0]);
                        end else begin
                            e = tx_exp_q.pop_front();
                            if (fr[7:0] !== e) begin
                                bad++;
                                $display("[TB] FAIL tx_byte: got=%02h expected=%02h", fr[7:0], e);
                            end
                        end
                        total++;
                        if (fr[8] !== 1'b1) begin
                            bad++;
                            $display("[TB] FAIL tx_stop_bit: got=%b expected=1", fr[8]);
                        end
                    end
                end
            end
        end
    end

    function automatic void modelRx(input logic [7:0] d, input logic stop_ok);
        if (!stop_ok)                        model_framing = 1'b1;
        else if (model_rx_q.size() < DEPTH) model_rx_q.push_back(d);
        else                                 model_overrun = 1'b1;
    endfunction

    function automatic logic [7:0] rxStatus();
        return {5'b0, model_framing, model_overrun, model_rx_q.size() != 0};
    endfunction

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
        outbus_addr = addr;
        outbus_data = data;
        outbus_we   = 1'b1;
        @(posedge clk);
        #1;
        outbus_we   = 1'b0;
    endtask

    task automatic checkOutput(input logic [7:0] addr, input logic pop,
                               input logic [7:0] expected, input string name);
        inbus_addr = addr;
        inbus_re   = pop;
        chk_req    = 1'b1;
        rd_exp_q.push_back(expected);
        rd_name_q.push_back(name);
        @(posedge clk);
        #1;
        inbus_re   = 1'b0;
        chk_req    = 1'b0;
    endtask

    task automatic checkDirect(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%02h expected=%02h", name, actual, expected);
        end
    endtask

    task automatic waitTxTick();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!rs232_tx_clk_en && n < 64);
        if (!rs232_tx_clk_en) begin
            total++;
            bad++;
            $display("[TB] FAIL tx_tick_timeout: got=none expected=tick");
        end
    endtask

    task automatic waitTxDrained(input int limit, input string name);
        int n;
        n = 0;
        while (tx_exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (tx_exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d pending expected=0", name, tx_exp_q.size());
        end
    endtask

    task automatic driveFrame(input logic [7:0] data, input logic stop_val);
        logic [9:0] bits;
        bits = {stop_val, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drive = bits[0];
            bits = bits >> 1;
            repeat (16) @(posedge clk);
            #1;
        end
        rx_drive = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        logic [9:0] frame;
        int         n;
        total = 0;
        bad = 0;
        reset = 1'b1;
        outbus_addr = '0;
        outbus_data = '0;
        outbus_we = 1'b0;
        inbus_addr = '0;
        inbus_re = 1'b0;
        chk_req = 1'b0;
        loopback = 1'b0;
        rx_drive = 1'b1;
        tx_run = 1'b1;
        model_overrun = 1'b0;
        model_framing = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkDirect("rst_complete_low", {7'b0, reset_complete}, 8'h00);
        checkDirect("rst_tx_pin", {7'b0, tx_pin}, 8'h01);
        checkOutput(A_TXS, 1'b0, 8'h02, "rst_tx_status");
        checkOutput(A_RXS, 1'b0, 8'h00, "rst_rx_status");
        checkOutput(A_RXD, 1'b0, 8'h00, "rst_rx_data");
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkDirect("rst_complete_high", {7'b0, reset_complete}, 8'h01);

        // Address decode: out-of-window and non-data writes are ignored
        tx_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(8'h00, 8'($urandom));
        applyStimulus(8'h44, 8'($urandom));
        applyStimulus(A_TXS, 8'($urandom));
        applyStimulus(A_RXD, 8'($urandom));
        applyStimulus(A_RXS, 8'($urandom));
        checkOutput(A_TXS, 1'b0, 8'h02, "ignored_writes");
        checkOutput(8'h01, 1'b0, 8'h00, "outside_read_low");
        checkOutput(8'h45, 1'b0, 8'h00, "outside_read_high");
        checkOutput(A_TXD, 1'b0, 8'h00, "offset0_read");

        // 0xA5 waveform and busy duration
        tx_run = 1'b1;
        applyStimulus(A_TXD, 8'hA5);
        tx_exp_q.push_back(8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            waitTxTick();
            #2;
            checkDirect("a5_tx_pin", {7'b0, tx_pin}, {7'b0, frame[0]});
            frame = frame >> 1;
            checkOutput(A_TXS, 1'b0, 8'h06, "a5_busy");
        end
        waitTxTick();
        #2;
        checkDirect("a5_idle_pin", {7'b0, tx_pin}, 8'h01);
        checkOutput(A_TXS, 1'b0, 8'h02, "a5_idle_status");

        // Loopback: fixed pair plus a few random bytes
        loopback = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(A_TXD, 8'h53);
        applyStimulus(A_TXD, 8'h0D);
        tx_exp_q.push_back(8'h53);
        tx_exp_q.push_back(8'h0D);
        modelRx(8'h53, 1'b1);
        modelRx(8'h0D, 1'b1);
        n = int'($urandom_range(0, 2));
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            applyStimulus(A_TXD, d);
            tx_exp_q.push_back(d);
            modelRx(d, 1'b1);
        end
        waitTxDrained(1000, "loopback_tx_drain");
        repeat (40) @(posedge clk);
        #1;
        checkOutput(A_RXS, 1'b0, rxStatus(), "lb_rx_status");
        while (model_rx_q.size() != 0) begin
            d = model_rx_q.pop_front();
            checkOutput(A_RXD, 1'b1, d, "lb_rx_data");
        end
        checkOutput(A_RXS, 1'b0, rxStatus(), "lb_rx_status_empty");
        checkOutput(A_RXD, 1'b1, 8'h00, "rx_pop_when_empty");
        checkOutput(A_RXS, 1'b0, 8'h00, "rx_status_after_empty_pop");
        loopback = 1'b0;

        // Stalled line: fill TX FIFO, fifth byte must be dropped
        tx_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom);
            applyStimulus(A_TXD, d);
            tx_exp_q.push_back(d);
            if (i == DEPTH - 2) checkOutput(A_TXS, 1'b0, 8'h00, "stall_partial");
        end
        checkOutput(A_TXS, 1'b0, 8'h01, "stall_full");
        applyStimulus(A_TXD, 8'($urandom));
        checkOutput(A_TXS, 1'b0, 8'h01, "stall_full_after_drop");
        tx_run = 1'b1;
        waitTxDrained(1200, "stall_tx_drain");
        repeat (400) @(posedge clk);
        #1;
        checkOutput(A_TXS, 1'b0, 8'h02, "stall_drained_status");

        // RX overrun: five frames, no reads
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            driveFrame(d, 1'b1);
            modelRx(d, 1'b1);
        end
        checkOutput(A_RXS, 1'b1, rxStatus(), "ovr_status");
        model_overrun = 1'b0;
        model_framing = 1'b0;
        checkOutput(A_RXS, 1'b0, rxStatus(), "ovr_cleared");
        while (model_rx_q.size() != 0) begin
            d = model_rx_q.pop_front();
            checkOutput(A_RXD, 1'b1, d, "ovr_rx_data");
        end
        checkOutput(A_RXS, 1'b0, rxStatus(), "ovr_final_status");

        // Framing error, then a single-tick glitch
        d = 8'($urandom);
        driveFrame(d, 1'b0);
        modelRx(d, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput(A_RXS, 1'b1, rxStatus(), "framing_status");
        model_framing = 1'b0;
        checkOutput(A_RXS, 1'b0, rxStatus(), "framing_cleared");
        rx_drive = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_drive = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        checkOutput(A_RXS, 1'b0, 8'h00, "glitch_status");

        // Reset in the middle of a TX frame
        d = 8'($urandom);
        applyStimulus(A_TXD, d);
        tx_exp_q.push_back(d);
        for (int i = 0; i < 4; i++) waitTxTick();
        #1;
        reset = 1'b1;
        tx_exp_q.delete();
        @(posedge clk);
        #1;
        checkDirect("midtx_rst_tx_pin", {7'b0, tx_pin}, 8'h01);
        checkDirect("midtx_rst_complete", {7'b0, reset_complete}, 8'h00);
        checkOutput(A_TXS, 1'b0, 8'h02, "midtx_rst_tx_status");
        checkOutput(A_RXS, 1'b0, 8'h00, "midtx_rst_rx_status");
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkDirect("midtx_complete_high", {7'b0, reset_complete}, 8'h01);
        repeat (300) @(posedge clk);
        #1;
        checkOutput(A_TXS, 1'b0, 8'h02, "post_reset_tx_status");
        checkOutput(A_RXS, 1'b0, 8'h00, "post_reset_rx_status");

        repeat (4) @(posedge clk);
        #1;
        total++;
        if (rd_exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL read_queue_leftover: got=%0d expected=0", rd_exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
